t08_lcd_seq: RTL and testbench

Command sequencer that sits directly upstream of the team's 8080-style LCD bus driver (`t08_spi`). It turns rectangle-fill requests into the driver's command/parameter transactions: CASET, PASET, MEMWRITE, then repeated memory-write-continue. Each transaction is handshaked on the driver's `busy` flag. Optionally, it runs a power-up init sequence before accepting requests.

---
 rtl/t08_lcd_pkg.sv | 39 +++
 rtl/t08_lcd_xact.sv | 67 ++++++
 rtl/t08_lcd_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_t08_lcd_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t08_lcd_pkg.sv
// Shared opcodes, state encodings and panel limits for the t08 LCD command sequencer.
package t08_lcd_pkg;

    localparam logic [7:0] LCD_SWRESET = 8'h01;
    localparam logic [7:0] LCD_SLPOUT  = 8'h11;
    localparam logic [7:0] LCD_COLMOD  = 8'h3A;
    localparam logic [7:0] LCD_DISPON  = 8'h29;
    localparam logic [7:0] LCD_CASET   = 8'h2A;
    localparam logic [7:0] LCD_PASET   = 8'h2B;
    localparam logic [7:0] LCD_MWR     = 8'h2C;
    localparam logic [7:0] LCD_MWC     = 8'h3C;

    localparam int XMAX_DEFAULT = 319;
    localparam int YMAX_DEFAULT = 239;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_MWR,
        ST_MWC,
        ST_FIN
    } top_state_t;

    typedef enum logic [2:0] {
        XS_IDLE,
        XS_ISSUE,
        XS_WAIT_HI,
        XS_WAIT_LO,
        XS_GAP
    } xact_state_t;

    // Address-window parameter: two 16-bit big-endian values, first byte in [31:24].
    function automatic logic [31:0] pack_range(input logic [8:0] lo, input logic [8:0] hi);
        return {7'b0, lo, 7'b0, hi};
    endfunction

endpackage

// File: rtl/t08_lcd_xact.sv
// One driver transaction: ISSUE, wait for busy high, wait for busy low, one-cycle enable gap.
module t08_lcd_xact
    import t08_lcd_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [31:0] par,
    input  logic [3:0]  cnt,
    input  logic        busy,
    output logic        xdone,
    output logic        spi_en,
    output logic [7:0]  spi_cmd,
    output logic [31:0] spi_par,
    output logic [3:0]  spi_cnt
);

    xact_state_t state, state_n;
    logic        load;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= XS_IDLE;
            spi_cmd <= '0;
            spi_par <= '0;
            spi_cnt <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                spi_cmd <= cmd;
                spi_par <= par;
                spi_cnt <= cnt;
            end
        end
    end

    // A new start is taken during GAP so consecutive transactions run back to back.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            XS_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = XS_ISSUE;
                end
            end
            XS_ISSUE:   state_n = XS_WAIT_HI;
            XS_WAIT_HI: if (busy) state_n = XS_WAIT_LO;
            XS_WAIT_LO: if (!busy) state_n = XS_GAP;
            XS_GAP: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = XS_ISSUE;
                end else begin
                    state_n = XS_IDLE;
                end
            end
            default: state_n = XS_IDLE;
        endcase
    end

    assign xdone  = (state == XS_GAP);
    assign spi_en = (state == XS_ISSUE) || (state == XS_WAIT_HI) || (state == XS_WAIT_LO);

endmodule

// File: rtl/t08_lcd_seq.sv
// Rectangle-fill command sequencer for the t08 LCD bus driver.
// Define T08_LCD_INIT_EN to run the panel power-up sequence after every reset.
module t08_lcd_seq
    import t08_lcd_pkg::*;
#(
    parameter logic [23:0] RESET_WAIT = 24'd600000,
    parameter int          XMAX       = XMAX_DEFAULT,
    parameter int          YMAX       = YMAX_DEFAULT
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_x0,
    input  logic [8:0]  req_x1,
    input  logic [8:0]  req_y0,
    input  logic [8:0]  req_y1,
    input  logic [23:0] req_color,
    output logic        done,
    output logic        err,
    output logic        spi_en,
    output logic [7:0]  spi_cmd,
    output logic [31:0] spi_par,
    output logic [3:0]  spi_cnt,
    output logic        spi_rw,
    input  logic        spi_busy
);

    localparam logic [8:0] XLIM = 9'(XMAX);
    localparam logic [8:0] YLIM = 9'(YMAX);

    top_state_t  state, state_n;
    logic        start, xdone, accept, reject, bad;
    logic [7:0]  xcmd;
    logic [31:0] xpar;
    logic [3:0]  xcnt;
    logic [8:0]  x0_q, x1_q, y0_q, y1_q, dx, dy;
    logic [23:0] color_q;
    logic [16:0] npix, rem;
    logic        ready_q, err_q;

`ifdef T08_LCD_INIT_EN
    logic [2:0]  init_step, init_step_n;
    logic [23:0] wcnt;
    logic        wload;
    localparam logic [23:0] WAIT_LAST = (RESET_WAIT == 24'd0) ? 24'd0 : RESET_WAIT - 24'd1;
    localparam top_state_t  RESET_STATE = ST_INIT;
`else
    localparam top_state_t  RESET_STATE = ST_IDLE;
`endif

    assign bad  = (req_x1 < req_x0) || (req_y1 < req_y0) || (req_x1 > XLIM) || (req_y1 > YLIM);
    assign dx   = x1_q - x0_q + 9'd1;
    assign dy   = y1_q - y0_q + 9'd1;
    assign npix = {8'b0, dx} * {8'b0, dy};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= RESET_STATE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            rem     <= '0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == ST_IDLE);
            err_q   <= reject;
            if (accept) begin
                x0_q    <= req_x0;
                x1_q    <= req_x1;
                y0_q    <= req_y0;
                y1_q    <= req_y1;
                color_q <= req_color;
            end
            if (state == ST_PASET && xdone) begin
                rem <= npix - 17'd1;
            end else if (state == ST_MWC && xdone) begin
                rem <= rem - 17'd1;
            end
        end
    end

`ifdef T08_LCD_INIT_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            init_step <= '0;
            wcnt      <= '0;
        end else begin
            init_step <= init_step_n;
            if (wload) begin
                wcnt <= WAIT_LAST;
            end else if (wcnt != 24'd0) begin
                wcnt <= wcnt - 24'd1;
            end
        end
    end
`endif

    // Each command state launches the next transaction during the current one's GAP.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        accept  = 1'b0;
        reject  = 1'b0;
        xcmd    = LCD_CASET;
        xpar    = '0;
        xcnt    = '0;
`ifdef T08_LCD_INIT_EN
        init_step_n = init_step;
        wload       = 1'b0;
`endif
        case (state)
            ST_INIT: begin
`ifdef T08_LCD_INIT_EN
                case (init_step)
                    3'd0: begin
                        start       = 1'b1;
                        xcmd        = LCD_SWRESET;
                        init_step_n = 3'd1;
                    end
                    3'd1, 3'd3: begin
                        if (xdone) begin
                            wload       = 1'b1;
                            init_step_n = init_step + 3'd1;
                        end
                    end
                    3'd2: begin
                        if (wcnt == 24'd0) begin
                            start       = 1'b1;
                            xcmd        = LCD_SLPOUT;
                            init_step_n = 3'd3;
                        end
                    end
                    3'd4: begin
                        if (wcnt == 24'd0) begin
                            start       = 1'b1;
                            xcmd        = LCD_COLMOD;
                            xpar        = 32'h6600_0000;
                            xcnt        = 4'd1;
                            init_step_n = 3'd5;
                        end
                    end
                    3'd5: begin
                        if (xdone) begin
                            start       = 1'b1;
                            xcmd        = LCD_DISPON;
                            init_step_n = 3'd6;
                        end
                    end
                    default: begin
                        if (xdone) begin
                            state_n = ST_IDLE;
                        end
                    end
                endcase
`else
                state_n = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (ready_q && req_valid) begin
                    if (bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        start   = 1'b1;
                        xcmd    = LCD_CASET;
                        xpar    = pack_range(req_x0, req_x1);
                        xcnt    = 4'd4;
                        state_n = ST_CASET;
                    end
                end
            end
            ST_CASET: begin
                if (xdone) begin
                    start   = 1'b1;
                    xcmd    = LCD_PASET;
                    xpar    = pack_range(y0_q, y1_q);
                    xcnt    = 4'd4;
                    state_n = ST_PASET;
                end
            end
            ST_PASET: begin
                if (xdone) begin
                    start   = 1'b1;
                    xcmd    = LCD_MWR;
                    xpar    = {color_q, 8'h00};
                    xcnt    = 4'd3;
                    state_n = ST_MWR;
                end
            end
            ST_MWR, ST_MWC: begin
                if (xdone) begin
                    if ((state == ST_MWR && rem == 17'd0) || (state == ST_MWC && rem == 17'd1)) begin
                        state_n = ST_FIN;
                    end else begin
                        start   = 1'b1;
                        xcmd    = LCD_MWC;
                        xpar    = {color_q, 8'h00};
                        xcnt    = 4'd3;
                        state_n = ST_MWC;
                    end
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = RESET_STATE;
        endcase
    end

    t08_lcd_xact u_xact (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .cmd     (xcmd),
        .par     (xpar),
        .cnt     (xcnt),
        .busy    (spi_busy),
        .xdone   (xdone),
        .spi_en  (spi_en),
        .spi_cmd (spi_cmd),
        .spi_par (spi_par),
        .spi_cnt (spi_cnt)
    );

    assign req_ready = ready_q;
    assign err       = err_q;
    assign done      = (state == ST_FIN);
    assign spi_rw    = 1'b1;

endmodule

// File: tb/tb_t08_lcd_seq.sv
// Scoreboard bench for t08_lcd_seq with a behavioural busy-handshake driver model.
// Covers T08_LCD_INIT_EN builds as well as the default build.
module tb_t08_lcd_seq;
    import t08_lcd_pkg::*;

    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
    logic [23:0] req_color = '0;
    logic        done, err, spi_en, spi_rw;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_cmd;
    logic [31:0] spi_par;
    logic [3:0]  spi_cnt;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] par;
        logic [3:0]  cnt;
        int          gap;
    } xact_t;

    xact_t expQ[$];
    int checkCnt = 0;
    int passCnt = 0;
    int doneSeen = 0;
    int errSeen = 0;
    int expDone = 0;
    int expErr = 0;
    int busyDelay = 0;
    int busyLen = 1;

    always #5 clk = ~clk;

    t08_lcd_seq #(.RESET_WAIT(24'd4), .XMAX(319), .YMAX(239)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_x1    (req_x1),
        .req_y0    (req_y0),
        .req_y1    (req_y1),
        .req_color (req_color),
        .done      (done),
        .err       (err),
        .spi_en    (spi_en),
        .spi_cmd   (spi_cmd),
        .spi_par   (spi_par),
        .spi_cnt   (spi_cnt),
        .spi_rw    (spi_rw),
        .spi_busy  (spi_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic failBound(input string name);
        checkCnt++;
        $display("[TB] FAIL %s: got timeout, expected event within %0d cycles at %0t", name, LIMIT, $time);
    endtask

    task automatic pushX(input logic [7:0] c, input logic [31:0] p, input logic [3:0] n, input int gap);
        xact_t it;
        it.cmd = c;
        it.par = p;
        it.cnt = n;
        it.gap = gap;
        expQ.push_back(it);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_spi_en"}, 32'(spi_en), 32'd0);
        checkOutput({tag, "_spi_cmd"}, 32'(spi_cmd), 32'd0);
        checkOutput({tag, "_spi_par"}, spi_par, 32'd0);
        checkOutput({tag, "_spi_cnt"}, 32'(spi_cnt), 32'd0);
        checkOutput({tag, "_spi_rw"}, 32'(spi_rw), 32'd1);
    endtask

    task automatic waitReady(input string name);
        int t = 0;
        while (req_ready !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (req_ready !== 1'b1) failBound(name);
    endtask

    task automatic doInit();
`ifdef T08_LCD_INIT_EN
        pushX(LCD_SWRESET, 32'h0, 4'd0, 0);
        pushX(LCD_SLPOUT, 32'h0, 4'd0, 5);
        pushX(LCD_COLMOD, 32'h6600_0000, 4'd1, 5);
        pushX(LCD_DISPON, 32'h0, 4'd0, 1);
        @(negedge clk);
        checkOutput("ready_low_during_init", 32'(req_ready), 32'd0);
        waitReady("init_ready_wait");
        checkOutput("init_cmds_before_ready", 32'(expQ.size()), 32'd0);
`else
        @(negedge clk);
        checkOutput("ready_after_release", 32'(req_ready), 32'd1);
`endif
    endtask

    task automatic applyStimulus(input logic [8:0] x0, input logic [8:0] x1, input logic [8:0] y0,
                                 input logic [8:0] y1, input logic [23:0] color, input logic rejected,
                                 input logic [31:0] expCaset, input logic [31:0] expPaset,
                                 input logic [31:0] expPix, input int nMwc);
        int t;
        if (!rejected) begin
            pushX(LCD_CASET, expCaset, 4'd4, 0);
            pushX(LCD_PASET, expPaset, 4'd4, 1);
            pushX(LCD_MWR, expPix, 4'd3, 1);
            for (int i = 0; i < nMwc; i++) pushX(LCD_MWC, expPix, 4'd3, 1);
        end
        waitReady("req_ready_wait");
        req_x0 = x0;
        req_x1 = x1;
        req_y0 = y0;
        req_y1 = y1;
        req_color = color;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (rejected) begin
            expErr++;
            checkOutput("err_pulse", 32'(err), 32'd1);
            checkOutput("ready_after_err", 32'(req_ready), 32'd1);
            @(negedge clk);
            checkOutput("err_one_cycle", 32'(err), 32'd0);
            repeat (4) @(negedge clk);
            checkOutput("no_xact_on_err", 32'(spi_en), 32'd0);
            checkOutput("ready_held_on_err", 32'(req_ready), 32'd1);
        end else begin
            expDone++;
            checkOutput("ready_drop", 32'(req_ready), 32'd0);
            checkOutput("caset_issue_next_cycle", 32'(spi_en), 32'd1);
            t = 0;
            while (done !== 1'b1 && t < LIMIT) begin
                @(negedge clk);
                t++;
            end
            if (done !== 1'b1) begin
                failBound("done_wait");
            end else begin
                @(negedge clk);
                checkOutput("done_one_cycle", 32'(done), 32'd0);
                checkOutput("ready_after_done", 32'(req_ready), 32'd1);
                checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
            end
        end
    endtask

    // Driver model: accept on enable, raise busy after busyDelay, hold busyLen, then await enable low.
    initial begin : driver
        int dphase = 0;
        int dcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!nrst) begin
                spi_busy = 1'b0;
                dphase = 0;
            end else begin
                case (dphase)
                    0: if (spi_en) begin
                        dcnt = busyDelay;
                        dphase = 1;
                    end
                    1: if (dcnt == 0) begin
                        spi_busy = 1'b1;
                        dcnt = busyLen - 1;
                        dphase = 2;
                    end else dcnt--;
                    2: if (dcnt == 0) begin
                        spi_busy = 1'b0;
                        dphase = 3;
                    end else dcnt--;
                    default: if (!spi_en) dphase = 0;
                endcase
            end
        end
    end

    // Monitor: every enable rise is a new transaction popped from the scoreboard.
    initial begin : monitor
        logic        prevEn = 1'b0;
        logic [1:0]  hist = 2'b00;
        int          lowCnt = 0;
        logic [7:0]  capCmd = '0;
        logic [31:0] capPar = '0;
        logic [3:0]  capCnt = '0;
        xact_t       it;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prevEn = 1'b0;
                hist = 2'b00;
                lowCnt = 0;
            end else begin
                if (spi_en && !prevEn) begin
                    if (expQ.size() == 0) begin
                        checkCnt++;
                        $display("[TB] FAIL unexpected_xact: got cmd 0x%02h par 0x%08h, expected none at %0t",
                                 spi_cmd, spi_par, $time);
                    end else begin
                        it = expQ.pop_front();
                        checkOutput("xact_cmd", 32'(spi_cmd), 32'(it.cmd));
                        checkOutput("xact_par", spi_par, it.par);
                        checkOutput("xact_cnt", 32'(spi_cnt), 32'(it.cnt));
                        if (it.gap > 0) checkOutput("en_low_gap", 32'(lowCnt), 32'(it.gap));
                    end
                    capCmd = spi_cmd;
                    capPar = spi_par;
                    capCnt = spi_cnt;
                end
                if (!spi_en && prevEn) begin
                    checkOutput("stable_cmd", 32'(spi_cmd), 32'(capCmd));
                    checkOutput("stable_par", spi_par, capPar);
                    checkOutput("stable_cnt", 32'(spi_cnt), 32'(capCnt));
                end
                if (done) begin
                    doneSeen++;
                    checkOutput("done_after_gap", 32'(hist), 32'b10);
                end
                if (err) errSeen++;
                lowCnt = spi_en ? 0 : lowCnt + 1;
                hist = {hist[0], spi_en};
                prevEn = spi_en;
            end
        end
    end

    initial begin : stimulus
        int t;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        nrst = 1'b1;
        doInit();

        applyStimulus(9'd3, 9'd3, 9'd5, 9'd5, 24'hFC0000, 1'b0,
                      32'h0003_0003, 32'h0005_0005, 32'hFC00_0000, 0);
        applyStimulus(9'd0, 9'd1, 9'd0, 9'd1, 24'h123456, 1'b0,
                      32'h0000_0001, 32'h0000_0001, 32'h1234_5600, 3);
        applyStimulus(9'd10, 9'd4, 9'd0, 9'd0, 24'h0, 1'b1, 32'h0, 32'h0, 32'h0, 0);
        applyStimulus(9'd0, 9'd320, 9'd0, 9'd0, 24'h0, 1'b1, 32'h0, 32'h0, 32'h0, 0);
        applyStimulus(9'd0, 9'd0, 9'd5, 9'd240, 24'h0, 1'b1, 32'h0, 32'h0, 32'h0, 0);
        applyStimulus(9'd0, 9'd319, 9'd0, 9'd0, 24'hFCFCFC, 1'b0,
                      32'h0000_013F, 32'h0000_0000, 32'hFCFC_FC00, 319);
        applyStimulus(9'd300, 9'd319, 9'd238, 9'd239, 24'h00FC00, 1'b0,
                      32'h012C_013F, 32'h00EE_00EF, 32'h00FC_0000, 39);

        busyDelay = 3;
        busyLen = 4;
        applyStimulus(9'd5, 9'd7, 9'd1, 9'd2, 24'h0000FC, 1'b0,
                      32'h0005_0007, 32'h0001_0002, 32'h0000_FC00, 5);

        // Reset while PASET sits in WAIT_LO with busy held high.
        busyDelay = 0;
        busyLen = 20;
        pushX(LCD_CASET, 32'h0002_0004, 4'd4, 0);
        pushX(LCD_PASET, 32'h0006_0008, 4'd4, 1);
        waitReady("midreset_ready_wait");
        req_x0 = 9'd2;
        req_x1 = 9'd4;
        req_y0 = 9'd6;
        req_y1 = 9'd8;
        req_color = 24'hFC00FC;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!(spi_cmd == LCD_PASET && spi_busy) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (!(spi_cmd == LCD_PASET && spi_busy)) failBound("paset_busy_wait");
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        checkResetValues("midreset");
        expQ.delete();
        busyLen = 1;
        nrst = 1'b1;
        doInit();
        applyStimulus(9'd3, 9'd3, 9'd5, 9'd5, 24'hFC0000, 1'b0,
                      32'h0003_0003, 32'h0005_0005, 32'hFC00_0000, 0);

        repeat (3) @(negedge clk);
        checkOutput("done_count", 32'(doneSeen), 32'(expDone));
        checkOutput("err_count", 32'(errSeen), 32'(expErr));
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
